// File: rtl/restador_serie_ctrl.sv
// Bit-serial subtractor controller: D = A - B, one bit per clock, LSB first,
// through a single cell built from two cascaded half subtractors.
module restador_serie_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ocupado,
  output logic             fin,
  output logic [WIDTH-1:0] diferencia,
  output logic             prestamo,
  output logic             desborde
);

  typedef enum logic [1:0] {IDLE, RESTA, FIN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [WIDTH-2:0]   sh_d;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;
  logic               a_msb;
  logic               b_msb;

  logic               r1;
  logic               p1;
  logic               d;
  logic               bo;
  logic [WIDTH-1:0]   res_next;

  // First half subtractor on the operand bits, second folds in the incoming borrow.
  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    r1       = sh_a[0] ^ sh_b[0];
    p1       = ~sh_a[0] & sh_b[0];
    d        = r1 ^ borrow;
    bo       = p1 | (~r1 & borrow);
    res_next = {d, sh_d};
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sh_a       <= '0;
      sh_b       <= '0;
      sh_d       <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ocupado    <= 1'b0;
      fin        <= 1'b0;
      diferencia <= '0;
      prestamo   <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fin <= 1'b0;
          if (inicio) begin
            sh_a    <= a;
            sh_b    <= b;
            borrow  <= 1'b0;
            cnt     <= '0;
            a_msb   <= a[WIDTH-1];
            b_msb   <= b[WIDTH-1];
            ocupado <= 1'b1;
            state   <= RESTA;
          end
        end
        RESTA: begin
          sh_d   <= res_next[WIDTH-1:1];
          sh_a   <= sh_a >> 1;
          sh_b   <= sh_b >> 1;
          borrow <= bo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            diferencia <= res_next;
            prestamo   <= bo;
            // Overflow only possible when operand signs differ; d is the result MSB here.
            desborde   <= (a_msb != b_msb) && (d != a_msb);
            ocupado    <= 1'b0;
            fin        <= 1'b1;
            state      <= FIN;
          end
        end
        FIN: begin
          fin   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          fin     <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serie_ctrl.sv
// Scoreboard bench for restador_serie_ctrl (WIDTH=8): directed vectors,
// expected results queued at issue and checked by a monitor on each fin pulse.
module tb_restador_serie_ctrl;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] dif;
    logic             pre;
    logic             des;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inicio = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ocupado;
  logic             fin;
  logic [WIDTH-1:0] diferencia;
  logic             prestamo;
  logic             desborde;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fin_count = 0;
  exp_t sb[$];

  restador_serie_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .inicio(inicio), .a(a), .b(b),
    .ocupado(ocupado), .fin(fin), .diferencia(diferencia),
    .prestamo(prestamo), .desborde(desborde)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every fin pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && fin) begin
      fin_count++;
      if (sb.size() == 0) begin
        check("unexpected_fin", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diferencia", 32'(diferencia), 32'(e.dif));
        check("prestamo", 32'(prestamo), 32'(e.pre));
        check("desborde", 32'(desborde), 32'(e.des));
      end
    end
  end

  task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input exp_t e);
    @(negedge clk);
    a = va;
    b = vb;
    inicio = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    inicio = 1'b0;
  endtask

  // Waits for fin, counting busy cycles and flagging any output change before fin.
  task automatic wait_fin(input string name, input int exp_busy);
    int n = 0;
    int busy = 0;
    logic changed = 1'b0;
    logic [WIDTH-1:0] held;
    held = diferencia;
    while (!fin && n < 40) begin
      if (ocupado) busy++;
      if (diferencia !== held) changed = 1'b1;
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= 40), 32'd0);
    if (exp_busy > 0) check({name, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
    check({name, "_held_during_resta"}, 32'(changed), 32'd0);
    check({name, "_ocupado_at_fin"}, 32'(ocupado), 32'd0);
    held = diferencia;
    @(negedge clk);
    check({name, "_fin_one_cycle"}, 32'(fin), 32'd0);
    check({name, "_held_after_fin"}, 32'(diferencia), 32'(held));
  endtask

  initial begin
    int t0;
    int fins_before;

    #12;
    check("reset_ocupado", 32'(ocupado), 32'd0);
    check("reset_fin", 32'(fin), 32'd0);
    check("reset_dif", 32'(diferencia), 32'd0);
    check("reset_pre", 32'(prestamo), 32'd0);
    check("reset_des", 32'(desborde), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(8'h35, 8'h12, '{dif: 8'h23, pre: 1'b0, des: 1'b0});
    wait_fin("op_35_12", WIDTH);
    issue(8'h12, 8'h35, '{dif: 8'hDD, pre: 1'b1, des: 1'b0});
    wait_fin("op_12_35", WIDTH);
    issue(8'h00, 8'h01, '{dif: 8'hFF, pre: 1'b1, des: 1'b0});
    wait_fin("op_00_01", WIDTH);
    issue(8'h80, 8'h01, '{dif: 8'h7F, pre: 1'b0, des: 1'b1});
    wait_fin("op_80_01", WIDTH);
    issue(8'h7F, 8'hFF, '{dif: 8'h80, pre: 1'b1, des: 1'b1});
    wait_fin("op_7F_FF", WIDTH);
    issue(8'h5A, 8'h5A, '{dif: 8'h00, pre: 1'b0, des: 1'b0});
    wait_fin("op_equal", WIDTH);

    // Re-request and operand changes during RESTA must be ignored.
    fins_before = fin_count;
    issue(8'h35, 8'h12, '{dif: 8'h23, pre: 1'b0, des: 1'b0});
    @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    inicio = 1'b1;
    @(negedge clk);
    @(negedge clk);
    inicio = 1'b0;
    a = 8'h00;
    b = 8'hC3;
    wait_fin("op_ignored_req", 0);
    repeat (12) @(negedge clk);
    check("ignored_req_single_fin", 32'(fin_count - fins_before), 32'd1);

    // inicio held high: two back-to-back operations WIDTH+2 cycles apart.
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    inicio = 1'b1;
    sb.push_back('{dif: 8'h0F, pre: 1'b0, des: 1'b0});
    sb.push_back('{dif: 8'h0F, pre: 1'b0, des: 1'b0});
    begin
      int n = 0;
      @(negedge clk);
      while (!fin && n < 40) begin @(negedge clk); n++; end
      t0 = cyc;
      @(negedge clk);
      n = 0;
      while (!fin && n < 40) begin @(negedge clk); n++; end
      inicio = 1'b0;
      check("b2b_spacing", 32'(cyc - t0), 32'(WIDTH + 2));
    end
    repeat (3) @(negedge clk);

    // Asynchronous reset at edge E4: no fin, everything back to reset values.
    fins_before = fin_count;
    @(negedge clk);
    a = 8'h12;
    b = 8'h35;
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_ocupado", 32'(ocupado), 32'd0);
    check("midreset_dif", 32'(diferencia), 32'd0);
    check("midreset_pre", 32'(prestamo), 32'd0);
    check("midreset_des", 32'(desborde), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_no_fin", 32'(fin_count - fins_before), 32'd0);
    check("midreset_outputs_stay", 32'({diferencia, prestamo, desborde}), 32'd0);

    issue(8'hAA, 8'h55, '{dif: 8'h55, pre: 1'b0, des: 1'b1});
    wait_fin("op_AA_55", WIDTH);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
